// File: rtl/alu_pipe.sv
// Handshaked, parametrised ALU with registered result/flags and a multi-cycle shift-add MUL.
// A new operation is only taken when IDLE and the current result slot is free or being drained.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   z,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned ShW  = $clog2(WIDTH) + 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpNot = 4'h5;
  localparam logic [3:0] OpShl = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpMul = 4'h8;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH:0]       z_q, z_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic [ShW-1:0]       shamt;
  logic [WIDTH:0]       alu_z;
  logic                 alu_err;
  logic [2*WIDTH-1:0]   acc_sum;

  assign shamt    = b[ShW-1:0];
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_sum  = acc_q + (mplr_q[0] ? mcand_q : '0);

  // Single-cycle datapath; MUL is handled by the sequencer below.
  always_comb begin
    alu_z   = '0;
    alu_err = 1'b0;
    case (operation)
      OpAdd:   alu_z = {1'b0, a} + {1'b0, b};
      OpSub:   alu_z = {1'b0, a} - {1'b0, b};
      OpAnd:   alu_z = {1'b0, a & b};
      OpOr:    alu_z = {1'b0, a | b};
      OpXor:   alu_z = {1'b0, a ^ b};
      OpNot:   alu_z = {1'b0, ~a};
      OpShl:   alu_z = {1'b0, a} << shamt;
      OpShr:   alu_z = {1'b0, a >> shamt};
      OpMul:   alu_z = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplr_d      = mplr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (operation == OpMul) begin
            mcand_d     = {{WIDTH{1'b0}}, a};
            mplr_d      = b;
            acc_d       = '0;
            cnt_d       = CntW'(WIDTH);
            out_valid_d = 1'b0;
            state_d     = StMul;
          end else begin
            z_d         = alu_z;
            zero_d      = (alu_z == '0);
            ovf_d       = 1'b0;
            err_d       = alu_err;
            out_valid_d = 1'b1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      StMul: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CntW'(1);
        // Last iteration: publish straight from the adder output.
        if (cnt_q == CntW'(1)) begin
          z_d         = acc_sum[WIDTH:0];
          zero_d      = (acc_sum[WIDTH:0] == '0);
          ovf_d       = |acc_sum[2*WIDTH-1:WIDTH+1];
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplr_q      <= mplr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expectations queued at accept, compared when the result drains.
module tb_alu_pipe;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W:0] z;
    logic       zero;
    logic       ovf;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   operation;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   z;
  logic         zero;
  logic         ovf;
  logic         err;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    exp_t        e;
    int          x;
    int          y;
    int unsigned p;
    logic [3:0]  sh;
    e  = '0;
    x  = int'(av);
    y  = int'(bv);
    sh = bv[3:0];
    case (op)
      4'h0: e.z = 9'(x + y);
      4'h1: e.z = 9'(x - y);
      4'h2: e.z = 9'(x & y);
      4'h3: e.z = 9'(x | y);
      4'h4: e.z = 9'(x ^ y);
      4'h5: e.z = 9'(255 - x);
      4'h6: e.z = (sh >= 9) ? 9'd0 : 9'(x << sh);
      4'h7: e.z = (sh >= 8) ? 9'd0 : 9'(x >> sh);
      4'h8: begin
        p     = x * y;
        e.z   = 9'(p);
        e.ovf = (p > 511);
      end
      default: begin
        e.z   = 9'd0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.z == 9'd0);
    return e;
  endfunction

  // Output side of the scoreboard: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result z=%0h zero=%0b ovf=%0b err=%0b", z, zero, ovf, err);
      end else begin
        mon_e = sb_q.pop_front();
        if ({z, zero, ovf, err} !== {mon_e.z, mon_e.zero, mon_e.ovf, mon_e.err}) begin
          errors++;
          $display("FAIL result got z=%0h zero=%0b ovf=%0b err=%0b want z=%0h zero=%0b ovf=%0b err=%0b",
                   z, zero, ovf, err, mon_e.z, mon_e.zero, mon_e.ovf, mon_e.err);
        end
      end
      pops++;
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    int n;
    n         = 0;
    operation = op;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0h in_ready=%0b want 1", op, in_ready);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    sb_q.push_back(model(op, av, bv));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, z, zero, ovf, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b z=%0h flags=%0b%0b%0b want all 0",
               out_valid, z, zero, ovf, err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sync();
  endtask

  task automatic test_add();
    logic [23:0] vec [3];
    vec = '{{4'h0, 8'd240, 8'd15}, {4'h0, 8'd0, 8'd0}, {4'h0, 8'd255, 8'd255}};
    out_ready = 1'b1;
    foreach (vec[i]) begin
      issue(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL add_latency[%0d] out_valid=%0b want 1", i, out_valid);
      end
      sync();
    end
  endtask

  task automatic test_ops();
    logic [19:0] vec [13];
    vec = '{{4'h1, 8'd240, 8'd15}, {4'h1, 8'd255, 8'd255}, {4'h1, 8'd0, 8'd1},
            {4'h2, 8'd240, 8'd15}, {4'h3, 8'd240, 8'd15}, {4'h4, 8'hA5, 8'h0F},
            {4'h5, 8'h0F, 8'h33},  {4'h6, 8'd255, 8'd1},  {4'h6, 8'd1, 8'd8},
            {4'h6, 8'd1, 8'd9},    {4'h7, 8'd240, 8'd4},  {4'h7, 8'd128, 8'd7},
            {4'h7, 8'd255, 8'd8}};
    out_ready = 1'b1;
    foreach (vec[i]) issue(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
    @(negedge clk);
    sync();
  endtask

  task automatic test_mul();
    logic [15:0] vec [3];
    vec = '{{8'd15, 8'd17}, {8'd255, 8'd255}, {8'd0, 8'd200}};
    out_ready = 1'b1;
    foreach (vec[k]) begin
      issue(4'h8, vec[k][15:8], vec[k][7:0]);
      // Present a competing op throughout; it must be ignored while busy.
      operation = 4'h0;
      a         = 8'd1;
      b         = 8'd1;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL mul_busy[%0d] cyc%0d out_valid=%0b in_ready=%0b want 0 0",
                   k, i, out_valid, in_ready);
        end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL mul_done[%0d] out_valid=%0b want 1", k, out_valid);
      end
      sync();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(4'h0, 8'd100, 8'd50);
    operation = 4'h3;
    a         = 8'd1;
    b         = 8'd2;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, z, zero, ovf, err, in_ready} !== {1'b1, 9'd150, 3'b000, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d] got v=%0b z=%0d flags=%0b%0b%0b rdy=%0b want v=1 z=150 flags=000 rdy=0",
                 i, out_valid, z, zero, ovf, err, in_ready);
      end
    end
    sync();
    out_ready = 1'b1;
    issue(4'h1, 8'd9, 8'd3);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || z !== 9'd6) begin
      errors++;
      $display("FAIL same_edge_accept got v=%0b z=%0d want v=1 z=6", out_valid, z);
    end
    sync();
  endtask

  task automatic test_illegal_stream();
    int p0;
    out_ready = 1'b1;
    issue(4'hB, 8'd5, 8'd6);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || z !== 9'd0) begin
      errors++;
      $display("FAIL illegal got err=%0b z=%0h want err=1 z=0", err, z);
    end
    sync();
    issue(4'h0, 8'd1, 8'd2);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got err=%0b want 0", err);
    end
    sync();
    p0 = pops;
    for (int i = 0; i < 10; i++) issue(4'h0, 8'(i * 20), 8'(i));
    @(negedge clk);
    #1;
    checks++;
    if (pops - p0 !== 10) begin
      errors++;
      $display("FAIL stream got %0d results in 10 cycles want 10", pops - p0);
    end
    sync();
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    issue(4'h0, 8'd1, 8'd2);
    @(negedge clk);
    sync();
    issue(4'h8, 8'd200, 8'd3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if ({out_valid, z, zero, ovf, err} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v=%0b z=%0h flags=%0b%0b%0b rdy=%0b want all 0 rdy=1",
               out_valid, z, zero, ovf, err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %0b want 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_result cyc%0d out_valid=%0b want 0", i, out_valid);
      end
    end
    sync();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    operation = '0;
    test_reset();
    test_add();
    test_ops();
    test_mul();
    test_backpressure();
    test_illegal_stream();
    test_reset_mid_mul();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same operand and result naming (a, b, operation, z, with z one bit wider than the operands) and the same encodings for ADD, SUB and AND. It adds OR, XOR, NOT, shifts and a multi-cycle shift-add multiply, plus registered flags. Valid/ready handshakes on both input and output let it sit between a sequencer and a result FIFO with back-pressure.

Parameters:
WIDTH, 8, operand width in bits; must be ≥2. z is WIDTH+1 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and operation are presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
operation  input  4  opcode
out_valid  output  1  z and flags hold a result
out_ready  input  1  downstream consumes the result
z  output  WIDTH+1  result
zero  output  1  z == 0
ovf  output  1  MUL product did not fit in WIDTH+1 bits
err  output  1  opcode was illegal

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; out_valid=0; z=0; zero=0; ovf=0; err=0; counter and multiply registers are cleared. Reset during MUL abandons the operation and emits no output.
- Accept: on an edge where in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from state, out_valid and out_ready only, never from in_valid.
- Output hold: while out_valid && !out_ready, z and all flags are held stable.
- out_valid clears on a handshake edge unless a new result is written on the same edge.
- Opcodes, single-cycle; the result is registered on the accepting edge and out_valid=1 in the following cycle:
  - 0000 ADD: z = a + b, full WIDTH+1 sum with the carry in the MSB.
  - 0001 SUB: z = ({0,a} − {0,b}) mod 2^(WIDTH+1). MSB=1 means borrow (a<b).
  - 0010 AND, 0011 OR, 0100 XOR: bitwise on a and b, zero-extended.
  - 0101 NOT: z = {0, ~a}; b is ignored.
  - 0110 SHL: z = a << b[$clog2(WIDTH):0]; bits beyond WIDTH+1 are lost; shift ≥ WIDTH+1 gives 0.
  - 0111 SHR: z = {0, a >> b[$clog2(WIDTH):0]}, logical shift; shift ≥ WIDTH gives 0.
  - 1001–1111: z=0, err=1, completes in one cycle.
- 1000 MUL, multi-cycle:
  - Accepting edge: latch multiplicand=a and multiplier=b; clear the 2·WIDTH accumulator; counter=WIDTH; state→MUL; out_valid→0.
  - Each MUL edge: add the shifted multiplicand to the accumulator if the current multiplier LSB=1; shift; decrement counter.
  - On the WIDTH-th edge after acceptance: z = product[WIDTH:0]; ovf = |product[2·WIDTH−1:WIDTH+1]; out_valid→1; state→IDLE.
  - in_ready=0 throughout MUL.
  - Operands of 0 still take the full WIDTH cycles; there is no early exit.
- Flags:
  - zero is recomputed with every result.
  - ovf=0 for every non-MUL op.
  - err=0 for every legal op.
- State machine: IDLE →(accept MUL) MUL →(counter reaches 0) IDLE. Every other accept stays in IDLE.
- Back-to-back single-cycle ops with out_ready held at 1 sustain one result per cycle.
- Inputs are ignored whenever in_ready=0.

Test Plan:
1. WIDTH=8, ADD: (240,15) → z=255, zero=0; (0,0) → z=0, zero=1; (255,255) → z=510 (9'h1FE). Each result has out_valid=1 one cycle after accept.
2. SUB: (240,15) → z=225; (255,255) → z=0, zero=1; (0,1) → z=9'h1FF (borrow). Also AND (240,15) → 0; OR (240,15) → 255; SHL (255, b=1) → 9'h1FE; SHR (240, b=4) → 15.
3. MUL (15,17) → z=255, ovf=0, out_valid asserts exactly 8 edges after accept, in_ready=0 meanwhile. MUL (255,255) → product 65025, z=1, ovf=1. MUL (0,200) → z=0, zero=1, still 8 cycles.
4. Back-pressure: hold out_ready=0 after an ADD result → z, flags and out_valid stay stable and in_ready=0. Release → handshake completes, and a new op is accepted on that same edge.
5. Illegal opcode 1011 → z=0, err=1; the next legal op clears err. Streaming ten ADDs with out_ready=1 → ten results in ten consecutive cycles.
6. Assert rst_n=0 mid-MUL (cycle 3) → outputs clear immediately without waiting for clk. After release: state IDLE, in_ready=1, and no stale result appears.
